// File: rtl/pad_shift_tx_pkg.sv
// Purpose : shared state encoding and counter-sizing helper for the pad serialiser.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
package pad_shift_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Smallest number of bits r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pad_shift_tx_timer.sv
// Purpose : bit-period timer; flags the mid-point and the last cycle of each DIV-cycle period.
// Latency : half/tick are decoded directly from the counter (same cycle); start clears it on the next edge.
// Backpr. : none, free-running between starts.
//
// Ports: clk, rst (async, active-high), start (restart period at 0),
//        half (counter == DIV/2-1), tick (counter == DIV-1).
module pad_bit_timer
    import pad_shift_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic half,
    output logic tick
);

    localparam int PW = clog2(DIV);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign half = (cnt_q == PW'(DIV / 2 - 1));
    assign tick = (cnt_q == PW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (start || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pad_shift_tx.sv
// Purpose : parallel-to-serial pad driver (sout MSB first, sclk strobe, frame) with one idle bit period after each word.
// Latency : pads change one edge after acceptance; next word can be accepted (WIDTH+1)*DIV+1 cycles later.
// Backpr. : ready_out is low from acceptance until the trailing gap period ends; inputs are ignored meanwhile.
//
// Ports: clk, rst (async, active-high), data_in[WIDTH], valid_in, ready_out,
//        sout (serial data), sclk_out (receiver samples on rising edge), frame_out (high across data bits).
module pad_shift_tx
    import pad_shift_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sout,
    output logic             sclk_out,
    output logic             frame_out
);

    localparam int BW = clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BW-1:0]    bit_q;
    logic             ready_q;
    logic             sout_q;
    logic             sclk_q;
    logic             frame_q;

    logic             accept;
    logic             half;
    logic             tick;
    logic             last_bit;

    assign accept   = valid_in && ready_q && (state_q == IDLE);
    assign shreg_d  = shreg_q << 1;
    assign last_bit = (bit_q == BW'(WIDTH - 1));

    // The timer restarts on acceptance so the first bit period is aligned to
    // the accept edge; afterwards it wraps on its own at every tick, which
    // also aligns the gap period.
    pad_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .half  (half),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            sout_q  <= 1'b0;
            sclk_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        shreg_q <= data_in;
                        bit_q   <= '0;
                        ready_q <= 1'b0;
                        frame_q <= 1'b1;
                        sclk_q  <= 1'b0;
                        // Pads are registered, so the MSB is driven straight from the input word.
                        sout_q  <= data_in[WIDTH-1];
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q  <= 1'b0;
                        shreg_q <= shreg_d;
                        bit_q   <= bit_q + BW'(1);
                        if (last_bit) begin
                            state_q <= GAP;
                            frame_q <= 1'b0;
                            sout_q  <= 1'b0;
                        end else begin
                            sout_q  <= shreg_d[WIDTH-1];
                        end
                    end else if (half) begin
                        // Rising strobe lands mid-bit, half a period after sout settles.
                        sclk_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    sout_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    frame_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign sout      = sout_q;
    assign sclk_out  = sclk_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_pad_shift_tx.sv
// Purpose : self-checking bench for pad_shift_tx at WIDTH=8/DIV=4 and WIDTH=1/DIV=2.
// Latency : n/a.
// Backpr. : n/a.
module tb_pad_shift_tx;

    localparam int AW = 8;
    localparam int AD = 4;
    localparam int BWD = 1;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_data = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready, a_sout, a_sclk, a_frame;

    logic       b_data = 1'b0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_sout, b_sclk, b_frame;

    always #5 clk = ~clk;

    pad_shift_tx #(.WIDTH(AW), .DIV(AD)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .data_in   (a_data),
        .valid_in  (a_valid),
        .ready_out (a_ready),
        .sout      (a_sout),
        .sclk_out  (a_sclk),
        .frame_out (a_frame)
    );

    pad_shift_tx #(.WIDTH(BWD), .DIV(BD)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .data_in   (b_data),
        .valid_in  (b_valid),
        .ready_out (b_ready),
        .sout      (b_sout),
        .sclk_out  (b_sclk),
        .frame_out (b_frame)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    // Each instance remembers the edge index of its last acceptance and the
    // word; the pads are a pure function of the number of edges since then.
    int         cyc = 0;
    logic       a_rok = 1'b0, a_busy = 1'b0;
    int         a_k = 0;
    logic [7:0] a_word = 8'h00;
    logic       b_rok = 1'b0, b_busy = 1'b0;
    int         b_k = 0;
    logic [7:0] b_word = 8'h00;

    // Returns {ready, frame, sclk, sout}.
    function automatic logic [3:0] expect_pads(input logic rok, input logic busy, input int e,
                                               input logic [7:0] word, input int w, input int d);
        logic [3:0] r;
        r = 4'b0000;
        if (busy && e < w * d) begin
            r[2] = 1'b1;
            r[1] = ((e % d) >= d / 2);
            r[0] = word[w - 1 - e / d];
        end else if (busy && e < (w + 1) * d) begin
            r = 4'b0000;
        end else begin
            r[3] = rok;
        end
        return r;
    endfunction

    function automatic logic can_accept(input logic rok, input logic busy, input int e,
                                        input int w, input int d);
        return rok && !(busy && e < (w + 1) * d);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            a_rok  <= 1'b0;
            a_busy <= 1'b0;
            b_rok  <= 1'b0;
            b_busy <= 1'b0;
        end else begin
            a_rok <= 1'b1;
            b_rok <= 1'b1;
            if (a_valid && can_accept(a_rok, a_busy, cyc - a_k, AW, AD)) begin
                a_busy <= 1'b1;
                a_k    <= cyc + 1;
                a_word <= a_data;
            end
            if (b_valid && can_accept(b_rok, b_busy, cyc - b_k, BWD, BD)) begin
                b_busy <= 1'b1;
                b_k    <= cyc + 1;
                b_word <= {7'd0, b_data};
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] ea, eb, aa, ab;
        ea = rst ? 4'b0000 : expect_pads(a_rok, a_busy, cyc - a_k, a_word, AW, AD);
        eb = rst ? 4'b0000 : expect_pads(b_rok, b_busy, cyc - b_k, b_word, BWD, BD);
        aa = {a_ready, a_frame, a_sclk, a_sout};
        ab = {b_ready, b_frame, b_sclk, b_sout};
        tests++;
        if (aa !== ea) begin
            fails++;
            $display("FAIL model_a cyc=%0d: {ready,frame,sclk,sout} got %b expected %b", cyc, aa, ea);
        end
        tests++;
        if (ab !== eb) begin
            fails++;
            $display("FAIL model_b cyc=%0d: {ready,frame,sclk,sout} got %b expected %b", cyc, ab, eb);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_a_ready(input int maxc);
        int n;
        n = 0;
        while (a_ready !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (a_ready !== 1'b1) chk("a_ready_timeout", 0, 1);
    endtask

    // Call at a negedge with a_ready high. mode 0: drop valid after accept;
    // mode 1: scribble valid/data (0x3C) while busy; mode 2: keep valid high, data -> 0x00.
    // Reported positions are in cycles after the accept edge (first cycle = 1).
    task automatic send_a(input logic [7:0] word, input int ncyc, input int mode,
                          output logic [7:0] bits, output int rises, output int first_rise,
                          output int last_rise, output int frame_cnt, output int ready_at,
                          output int gap_zero);
        logic prev;
        a_data  = word;
        a_valid = 1'b1;
        @(posedge clk);
        bits = 8'h00; rises = 0; first_rise = -1; last_rise = -1;
        frame_cnt = 0; ready_at = -1; gap_zero = 0; prev = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            @(negedge clk);
            if (e == 0) begin
                if (mode == 2) a_data = 8'h00;
                else a_valid = 1'b0;
            end
            if (mode == 1) begin
                a_data  = 8'h3C;
                a_valid = (e < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (a_frame && (e % AD) == 0 && (e / AD) < AW) bits[AW - 1 - e / AD] = a_sout;
            if (a_sclk && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = e + 1;
                last_rise = e + 1;
            end
            prev = a_sclk;
            if (a_frame) frame_cnt++;
            if (a_ready && ready_at < 0) ready_at = e + 1;
            if (e >= AW * AD && e < (AW + 1) * AD && !a_frame && !a_sclk && !a_sout) gap_zero++;
        end
    endtask

    initial begin
        logic [7:0] bits;
        int rises, fr, lr, fc, ra, gz;
        int bfc, bsclk_e1, bsclk_cnt, bsout_cnt, bra;

        // ---- reset release ----
        @(negedge clk);
        chk("rst_a_pads", int'({a_ready, a_frame, a_sclk, a_sout}), 0);
        chk("rst_b_pads", int'({b_ready, b_frame, b_sclk, b_sout}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_low_before_edge", int'(a_ready), 0);
        @(negedge clk);
        chk("ready_after_release_a", int'(a_ready), 1);
        chk("ready_after_release_b", int'(b_ready), 1);

        // ---- 0xA5 ----
        send_a(8'hA5, 40, 0, bits, rises, fr, lr, fc, ra, gz);
        chk("a5_bits", int'(bits), 8'hA5);
        chk("a5_sclk_rises", rises, 8);
        chk("a5_first_rise", fr, 3);
        chk("a5_last_rise", lr, 31);
        chk("a5_frame_cycles", fc, 32);
        chk("a5_ready_back", ra, 37);
        chk("a5_gap_zero", gz, 4);

        // ---- back-to-back 0xFF then 0x00 ----
        send_a(8'hFF, 37, 2, bits, rises, fr, lr, fc, ra, gz);
        chk("ff_bits", int'(bits), 8'hFF);
        chk("ff_frame_cycles", fc, 32);
        chk("ff_gap_zero", gz, 4);
        chk("ff_ready_back", ra, 37);
        @(negedge clk);
        a_valid = 1'b0;
        chk("b2b_ready_low", int'(a_ready), 0);
        chk("b2b_frame_high", int'(a_frame), 1);
        wait_a_ready(60);
        @(negedge clk);

        // ---- busy-input test ----
        send_a(8'h81, 40, 1, bits, rises, fr, lr, fc, ra, gz);
        chk("busy_bits", int'(bits), 8'h81);
        chk("busy_frame_cycles", fc, 32);
        chk("busy_ready_back", ra, 37);
        chk("busy_no_extra_accept", int'(a_ready), 1);

        // ---- mid-word reset on 0xC3 ----
        a_data  = 8'hC3;
        a_valid = 1'b1;
        @(posedge clk);
        for (int e = 0; e <= 14; e++) begin
            @(negedge clk);
            if (e == 0) a_valid = 1'b0;
        end
        chk("c3_frame_before_rst", int'(a_frame), 1);
        chk("c3_sclk_before_rst", int'(a_sclk), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("c3_async_pads", int'({a_ready, a_frame, a_sclk, a_sout}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("c3_ready_after_rst", int'(a_ready), 1);
        send_a(8'h5A, 40, 0, bits, rises, fr, lr, fc, ra, gz);
        chk("5a_bits", int'(bits), 8'h5A);
        chk("5a_frame_cycles", fc, 32);
        chk("5a_ready_back", ra, 37);

        // ---- WIDTH=1, DIV=2 ----
        b_data  = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        bfc = 0; bsclk_e1 = 0; bsclk_cnt = 0; bsout_cnt = 0; bra = -1;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            if (e == 0) b_valid = 1'b0;
            if (b_frame) bfc++;
            if (b_frame && b_sout) bsout_cnt++;
            if (b_sclk) bsclk_cnt++;
            if (b_sclk && e == 1) bsclk_e1 = 1;
            if (b_ready && bra < 0) bra = e + 1;
        end
        chk("w1_frame_cycles", bfc, 2);
        chk("w1_sout_high", bsout_cnt, 2);
        chk("w1_sclk_cycles", bsclk_cnt, 1);
        chk("w1_sclk_second", bsclk_e1, 1);
        chk("w1_ready_back", bra, 5);

        // ---- randomized traffic on both instances ----
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a_valid = ($urandom_range(0, 3) == 0);
            a_data  = 8'($urandom);
            b_valid = ($urandom_range(0, 2) == 0);
            b_data  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rand_async_pads", int'({a_ready, a_frame, a_sclk, a_sout}), 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (45) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
